// File: rtl/sdc_supervisor.sv
// ============================================================================
// sdc_supervisor : shutdown-circuit supervisor (sync, debounce, watchdog, FSM)
// Optional watchdog monitor: define SDC_WATCHDOG_EN.        Revision 1.0
// ============================================================================
`default_nettype none

module sdc_supervisor #(
    parameter int N_LOOPS           = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int WD_TIMEOUT_CYCLES = 50000
) (
    input  logic               Clock,
    input  logic               Power_on_Reset_n,
    input  logic               AS_close_SDC,
    input  logic               AS_driving_mode,
    input  logic               TS_Activation_Button_cockpit,
    input  logic               TS_Activation_Button_external,
    input  logic               Watchdog,
    input  logic [N_LOOPS-1:0] Shutdown_loop,
    output logic               To_SDC_relais,
    output logic               SDC_is_Ready,
    output logic [1:0]         SDC_state,
    output logic [N_LOOPS+1:0] Open_cause
);

    localparam int NS  = N_LOOPS + 4;   // loops, cockpit, external, close, mode
    localparam int NF  = N_LOOPS + 2;   // debounced: loops + two buttons
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int WDW = $clog2(WD_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_READY   = 2'd1,
        ST_CLOSED  = 2'd2,
        ST_TRIPPED = 2'd3
    } state_t;

    // Reset asserts asynchronously, releases on the clock.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge Clock or negedge Power_on_Reset_n) begin
        if (!Power_on_Reset_n) r_rst_sync <= 2'b00;
        else                   r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [NS-1:0] w_raw;
    logic [NS-1:0] r_s1;
    logic [NS-1:0] r_s2;

    assign w_raw = {AS_driving_mode, AS_close_SDC, TS_Activation_Button_external,
                    TS_Activation_Button_cockpit, Shutdown_loop};

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    logic [NF-1:0] w_filt;

    generate
        for (genvar i = 0; i < NF; i++) begin : g_filt
            logic [CW-1:0] r_cnt;
            logic          r_f;

            always_ff @(posedge Clock or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_cnt <= '0;
                    r_f   <= 1'b0;
                end else if (r_s2[i] == r_f) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_f   <= r_s2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            assign w_filt[i] = r_f;
        end
    endgenerate

    logic w_wd_ok;

`ifdef SDC_WATCHDOG_EN
    logic [2:0]     r_wd_sh;    // [1:0] synchroniser, [2] previous synchronised level
    logic [WDW-1:0] r_wd_cnt;
    logic           r_wd_ok;

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wd_sh  <= '0;
            r_wd_cnt <= '0;
            r_wd_ok  <= 1'b0;
        end else begin
            r_wd_sh <= {r_wd_sh[1:0], Watchdog};
            if (r_wd_sh[2] != r_wd_sh[1]) begin
                r_wd_cnt <= '0;
                r_wd_ok  <= 1'b1;
            end else if (r_wd_cnt != WDW'(WD_TIMEOUT_CYCLES)) begin
                r_wd_cnt <= r_wd_cnt + WDW'(1);
                if (r_wd_cnt == WDW'(WD_TIMEOUT_CYCLES - 1)) r_wd_ok <= 1'b0;
            end
        end
    end
    assign w_wd_ok = r_wd_ok;
`else
    logic w_unused_wd;
    assign w_unused_wd = Watchdog;
    assign w_wd_ok     = 1'b1;
`endif

    logic [N_LOOPS-1:0] w_loop_f;
    logic               w_loops_ok;
    logic               w_as_close;
    logic               w_mode;
    logic               w_sel;
    logic               w_act;
    logic               r_sel_prev;
    logic               r_mode_prev;

    assign w_loop_f   = w_filt[N_LOOPS-1:0];
    assign w_loops_ok = (&w_loop_f) & w_wd_ok;
    assign w_as_close = r_s2[N_LOOPS+2];
    assign w_mode     = r_s2[N_LOOPS+3];
    assign w_sel      = w_mode ? w_filt[N_LOOPS+1] : w_filt[N_LOOPS];
    // A mode change swaps the button source; that swap must not look like a press.
    assign w_act      = w_sel & ~r_sel_prev & (w_mode == r_mode_prev);

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sel_prev  <= 1'b0;
            r_mode_prev <= 1'b0;
        end else begin
            r_sel_prev  <= w_sel;
            r_mode_prev <= w_mode;
        end
    end

    state_t             r_state;
    state_t             w_next;
    logic [N_LOOPS+1:0] w_trip_cause;
    logic [N_LOOPS+1:0] r_cause;
    logic               r_relay;
    logic               r_ready;

    // Losing AS_close_SDC is only a fault once the circuit is closed.
    assign w_trip_cause = {(r_state == ST_CLOSED) & ~w_as_close, ~w_wd_ok, ~w_loop_f};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OPEN:    if (w_loops_ok) w_next = ST_READY;
            ST_READY: begin
                if (!w_loops_ok)              w_next = ST_TRIPPED;
                else if (w_act && w_as_close) w_next = ST_CLOSED;
            end
            ST_CLOSED:  if (!w_loops_ok || !w_as_close) w_next = ST_TRIPPED;
            ST_TRIPPED: if (w_loops_ok && !w_as_close && !w_sel) w_next = ST_OPEN;
            default:    w_next = ST_OPEN;
        endcase
    end

    always_ff @(posedge Clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_OPEN;
            r_relay <= 1'b0;
            r_ready <= 1'b0;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            r_relay <= (w_next == ST_CLOSED);
            r_ready <= (w_next == ST_READY) || (w_next == ST_CLOSED);
            if (w_next == ST_TRIPPED && r_state != ST_TRIPPED)
                r_cause <= w_trip_cause;
            else if (r_state == ST_TRIPPED && w_next == ST_OPEN)
                r_cause <= '0;
        end
    end

    assign To_SDC_relais = r_relay;
    assign SDC_is_Ready  = r_ready;
    assign SDC_state     = r_state;
    assign Open_cause    = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_sdc_supervisor.sv
// ============================================================================
// tb_sdc_supervisor : vector table, directed corner sequences, random vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sdc_supervisor;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       as_c, mode, cock, ext, wd, wd_en;
    logic [3:0] loops;
    logic       relay, ready;
    logic [1:0] state;
    logic [5:0] cause;
    logic [9:0] w_outs;

    int vectors = 0;
    int fails   = 0;

    sdc_supervisor #(
        .N_LOOPS(4), .DEBOUNCE_CYCLES(D), .WD_TIMEOUT_CYCLES(100)
    ) dut (
        .Clock                         (clk),
        .Power_on_Reset_n              (rst_n),
        .AS_close_SDC                  (as_c),
        .AS_driving_mode               (mode),
        .TS_Activation_Button_cockpit  (cock),
        .TS_Activation_Button_external (ext),
        .Watchdog                      (wd),
        .Shutdown_loop                 (loops),
        .To_SDC_relais                 (relay),
        .SDC_is_Ready                  (ready),
        .SDC_state                     (state),
        .Open_cause                    (cause)
    );

    always #5 clk = ~clk;

    assign w_outs = {state, relay, ready, cause};

    initial begin
        wd = 1'b0;
        forever begin
            repeat (20) @(negedge clk);
            if (wd_en) wd = ~wd;
        end
    end

    function automatic logic [9:0] pk(input logic [1:0] st, input logic [5:0] c);
        return {st, st == 2'd2, (st == 2'd1) || (st == 2'd2), c};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d relay=%0b ready=%0b cause=%b, expected st=%0d relay=%0b ready=%0b cause=%b",
                     name, got[9:8], got[7], got[6], got[5:0], exp[9:8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_st(input logic [1:0] st, input int budget);
        for (int i = 0; i < budget && state !== st; i++) @(negedge clk);
    endtask

    task automatic recover(input string name, input int n);
        loops = 4'hF; as_c = 1'b0; ext = 1'b0; cock = 1'b0; mode = 1'b1;
        cyc(n);
        check(name, w_outs, pk(2'd1, 6'b0));
    endtask

    task automatic close_sdc(input string name);
        as_c = 1'b1; ext = 1'b1;
        wait_st(2'd2, 30);
        ext = 1'b0;
        cyc(10);
        check(name, w_outs, pk(2'd2, 6'b0));
    endtask

    typedef struct {
        logic [3:0] loops;
        logic       as_c, mode, ext, cock;
        int         hold;
        logic [1:0] st;
        logic [5:0] cause;
    } vec_t;

    vec_t tbl[14];

    logic [5:0] hist[$];     // {as, ext, loops}, hist[0] = value at current edge
    logic [1:0] m_st, m_nx;
    logic [5:0] m_cause;
    logic [4:0] m_filt;      // {ext, loops}
    logic       m_extprev, m_ok, m_act, m_as, m_v, m_same;

    initial begin
        tbl[0]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 40, 2'd1, 6'b000000};
        tbl[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 12, 2'd2, 6'b000000};
        tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2'd2, 6'b000000};
        tbl[3]  = '{4'hB, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2'd3, 6'b000100};
        tbl[4]  = '{4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 12, 2'd3, 6'b000100};
        tbl[5]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd1, 6'b000000};
        tbl[6]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 12, 2'd2, 6'b000000};
        tbl[7]  = '{4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 12, 2'd3, 6'b100000};
        tbl[8]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd1, 6'b000000};
        tbl[9]  = '{4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd3, 6'b000001};
        tbl[10] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd1, 6'b000000};
        tbl[11] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 12, 2'd2, 6'b000000};
        tbl[12] = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 12, 2'd3, 6'b001000};
        tbl[13] = '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 12, 2'd1, 6'b000000};

        rst_n = 1'b0; wd_en = 1'b1;
        loops = 4'hF; as_c = 1'b0; mode = 1'b1; cock = 1'b0; ext = 1'b0;
        cyc(3);
        check("reset_state", w_outs, pk(2'd0, 6'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            loops = tbl[i].loops; as_c = tbl[i].as_c; mode = tbl[i].mode;
            ext = tbl[i].ext; cock = tbl[i].cock;
            cyc(tbl[i].hold);
            check($sformatf("table%0d", i), w_outs, pk(tbl[i].st, tbl[i].cause));
        end

        // Loop trip latency: relay must fall on exactly the 7th edge.
        close_sdc("close_latency");
        loops = 4'hB;
        for (int e = 1; e <= D + 3; e++) begin
            @(posedge clk); #1;
            if (e == D + 2) check("latency_edge6", w_outs, pk(2'd2, 6'b0));
            if (e == D + 3) check("latency_edge7", w_outs, pk(2'd3, 6'b000100));
        end
        @(negedge clk);
        recover("recover_latency", 20);

        // Debounce: 3-cycle glitch is filtered, 4-cycle pulse trips.
        close_sdc("close_debounce");
        loops = 4'hE; cyc(D - 1); loops = 4'hF; cyc(12);
        check("glitch3", w_outs, pk(2'd2, 6'b0));
        loops = 4'hE; cyc(D); loops = 4'hF; cyc(12);
        check("pulse4", w_outs, pk(2'd3, 6'b000001));
        recover("recover_debounce", 20);

        // Watchdog stall while closed.
        close_sdc("close_wd");
        wd_en = 1'b0;
        cyc(60);
        check("wd_before_timeout", w_outs, pk(2'd2, 6'b0));
`ifdef SDC_WATCHDOG_EN
        wait_st(2'd3, 80);
        check("wd_timeout", w_outs, pk(2'd3, 6'b010000));
`else
        cyc(100);
        check("wd_ignored", w_outs, pk(2'd2, 6'b0));
`endif
        wd_en = 1'b1;
        recover("recover_wd", 40);

        // Driving-mode switch must not count as a button press.
        mode = 1'b0; cock = 1'b1; cyc(12);
        check("cock_held", w_outs, pk(2'd1, 6'b0));
        as_c = 1'b1; cyc(12);
        check("cock_held_close", w_outs, pk(2'd1, 6'b0));
        mode = 1'b1; cyc(12);
        check("mode_switch_cock", w_outs, pk(2'd1, 6'b0));
        mode = 1'b0; cock = 1'b0; ext = 1'b1; cyc(12);
        check("ext_held_hidden", w_outs, pk(2'd1, 6'b0));
        mode = 1'b1; cyc(12);
        check("mode_switch_ext", w_outs, pk(2'd1, 6'b0));
        recover("recover_mode", 20);

        // Loop drop and activation land on the same cycle.
        as_c = 1'b1; cyc(4);
        loops = 4'hD; ext = 1'b1; cyc(12);
        check("drop_and_act", w_outs, pk(2'd3, 6'b000010));
        recover("recover_simul", 20);

        // Asynchronous reset while closed, checked between clock edges.
        close_sdc("close_reset");
        #2 rst_n = 1'b0;
        #1 check("async_reset", w_outs, pk(2'd0, 6'b0));
        cyc(2);
        rst_n = 1'b1;
        recover("recover_reset", 40);

        // Random stimulus against a history-based reference model.
        m_st = 2'd1; m_cause = 6'b0; m_filt = 5'b01111; m_extprev = 1'b0;
        hist.delete();
        for (int i = 0; i < 12; i++) hist.push_front(6'b001111);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0)
                loops = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 19) == 0) as_c = ~as_c;
            if ($urandom_range(0, 11) == 0) ext = ~ext;
            @(posedge clk);
            hist.push_front({as_c, ext, loops});
            hist.pop_back();
            m_as  = hist[2][5];
            m_ok  = &m_filt[3:0];
            m_act = m_filt[4] & ~m_extprev;
            m_nx  = m_st;
            case (m_st)
                2'd0: if (m_ok) m_nx = 2'd1;
                2'd1: if (!m_ok) m_nx = 2'd3; else if (m_act && m_as) m_nx = 2'd2;
                2'd2: if (!m_ok || !m_as) m_nx = 2'd3;
                default: if (m_ok && !m_as && !m_filt[4]) m_nx = 2'd0;
            endcase
            if (m_nx == 2'd3 && m_st != 2'd3)
                m_cause = {(m_st == 2'd2) && !m_as, 1'b0, ~m_filt[3:0]};
            else if (m_st == 2'd3 && m_nx == 2'd0)
                m_cause = 6'b0;
            m_st = m_nx;
            m_extprev = m_filt[4];
            for (int b = 0; b < 5; b++) begin
                m_v = hist[2][b];
                m_same = 1'b1;
                for (int j = 2; j <= D + 1; j++) if (hist[j][b] != m_v) m_same = 1'b0;
                if (m_same) m_filt[b] = m_v;
            end
            #1 check($sformatf("random%0d", c), w_outs, pk(m_st, m_cause));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
